// File: rtl/fetch_unit.sv
// fetch_unit
// Instruction-fetch front end. Holds the PC, issues one outstanding request
// at a time to instruction memory, and presents each fetched instruction with
// its PC to decode. Resolved control flow from execute (ex_*) redirects the
// PC and discards whatever instruction is buffered or still in flight.
//
// Ports
//   clk, rst               : clock, asynchronous active-high reset
//   imem_req / imem_addr   : request valid / address (the internal PC)
//   imem_gnt               : memory accepts the request this cycle
//   imem_rvalid/imem_rdata : response valid / instruction word
//   id_valid / id_inst     : instruction available to decode / the word
//   id_pc / id_pc4         : PC of id_inst / id_pc + 4
//   id_ready               : decode accepts the instruction this cycle
//   ex_valid, ex_pc_sel, ex_pc, ex_imm, ex_rs1, ex_br_taken : resolved flow
//   dbg_state              : current FSM state (IDLE=0 REQ=1 RESP=2 HOLD=3 DROP=4)
//
// Handshakes: a transfer happens on a rising edge where the producer's valid
// (imem_req, id_valid) and the consumer's accept (imem_gnt, id_ready) are
// both high. Once raised, id_valid and its payload hold until accepted or a
// redirect discards them.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_inst,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc4,
  input  logic        id_ready,
  input  logic        ex_valid,
  input  logic [1:0]  ex_pc_sel,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_imm,
  input  logic [31:0] ex_rs1,
  input  logic        ex_br_taken,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_RESP = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_e;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc_q, id_pc_d;

  logic        redirect;
  logic [31:0] target;

  // Redirect decode: jal, jalr, or a taken conditional branch.
  always_comb begin
    redirect = ex_valid & ((ex_pc_sel == 2'b01) | (ex_pc_sel == 2'b10) |
                           ((ex_pc_sel == 2'b11) & ex_br_taken));
    if (ex_pc_sel == 2'b10) begin
      target = (ex_rs1 + ex_imm) & ~32'h1;
    end else begin
      target = ex_pc + ex_imm;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      id_inst_q <= NOP;
      id_pc_q   <= RESET_PC;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      id_inst_q <= id_inst_d;
      id_pc_q   <= id_pc_d;
    end
  end

  // Redirect is evaluated first in every state so it overrides the normal
  // transition; a granted or pending request then has to be drained in DROP.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    id_inst_d = id_inst_q;
    id_pc_d   = id_pc_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (redirect) pc_d = target;
      end
      S_REQ: begin
        if (redirect) begin
          pc_d    = target;
          state_d = imem_gnt ? S_DROP : S_REQ;
        end else if (imem_gnt) begin
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (redirect) begin
          pc_d    = target;
          state_d = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          id_inst_d = imem_rdata;
          id_pc_d   = pc_q;
          pc_d      = pc_q + 32'd4;
          state_d   = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = S_REQ;
        end else if (id_ready) begin
          state_d = S_REQ;
        end
      end
      S_DROP: begin
        if (redirect) pc_d = target;
        if (imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign id_valid  = (state_q == S_HOLD);
  assign id_inst   = id_inst_q;
  assign id_pc     = id_pc_q;
  assign id_pc4    = id_pc_q + 32'd4;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        id_valid, id_ready;
  logic [31:0] id_inst, id_pc, id_pc4;
  logic        ex_valid, ex_br_taken;
  logic [1:0]  ex_pc_sel;
  logic [31:0] ex_pc, ex_imm, ex_rs1;
  logic [2:0]  dbg_state;

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4),
    .id_ready(id_ready),
    .ex_valid(ex_valid), .ex_pc_sel(ex_pc_sel), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_br_taken(ex_br_taken),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  int          cyc_cnt = 0;
  int          accepts = 0;
  logic [31:0] exp_q[$];       // expected PCs of in-order delivered instructions

  logic [31:0] model_pc;
  bit          stall_prev;
  logic [31:0] prev_inst, prev_pc;

  // memory model
  int          gnt_pct = 100;
  int          lat_min = 1, lat_max = 1;
  bit          pend;
  int          lat;
  logic [31:0] paddr;
  bit          force_en;
  logic [31:0] force_data;
  bit          saw_bad;

  // stimulus for the next edge
  logic        nx_ex_valid, nx_br_taken, nx_ready;
  logic [1:0]  nx_sel;
  logic [31:0] nx_ex_pc, nx_imm, nx_rs1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc_cnt);
    end
  endtask

  task automatic clear_ex();
    nx_ex_valid = 1'b0; nx_sel = 2'b00; nx_br_taken = 1'b0;
    nx_ex_pc = 32'h0; nx_imm = 32'h0; nx_rs1 = 32'h0;
  endtask

  task automatic model_reset();
    model_pc   = RST_PC;
    pend       = 1'b0;
    stall_prev = 1'b0;
    exp_q.delete();
  endtask

  // ---------------- driver + reference model, one cycle ----------------
  // Runs at the falling edge: observes the outputs produced by the last
  // rising edge, drives inputs for the next one, and advances the model.
  task automatic cycle();
    bit          redir;
    logic [31:0] tgt;
    @(negedge clk);
    cyc_cnt++;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    if (rst) begin
      imem_gnt = 1'b0;
      model_reset();
      ex_valid = 1'b0; id_ready = 1'b0;
      return;
    end
    if (pend) begin
      lat--;
      if (lat == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = force_en ? force_data : mem_word(paddr);
        force_en    = 1'b0;
        pend        = 1'b0;
      end
    end
    imem_gnt = ($urandom_range(99) < gnt_pct);
    if (imem_req && imem_gnt) begin
      check_eq("grant_addr", imem_addr, model_pc);
      pend  = 1'b1;
      lat   = $urandom_range(lat_max, lat_min);
      paddr = imem_addr;
    end
    ex_valid = nx_ex_valid; ex_pc_sel = nx_sel; ex_br_taken = nx_br_taken;
    ex_pc = nx_ex_pc; ex_imm = nx_imm; ex_rs1 = nx_rs1; id_ready = nx_ready;

    check_eq("req_xor_valid", {31'b0, imem_req & id_valid}, 32'h0);
    if (stall_prev) begin
      check_eq("hold_valid", {31'b0, id_valid}, 32'h1);
      check_eq("hold_inst", id_inst, prev_inst);
      check_eq("hold_pc", id_pc, prev_pc);
    end
    if (id_valid) begin
      if (id_inst == 32'hDEAD_BEEF) saw_bad = 1'b1;
      check_eq("id_pc", id_pc, model_pc);
      check_eq("id_inst", id_inst, mem_word(id_pc));
      check_eq("id_pc4", id_pc4, id_pc + 32'd4);
    end

    redir = ex_valid && (ex_pc_sel == 2'b01 || ex_pc_sel == 2'b10 ||
                         (ex_pc_sel == 2'b11 && ex_br_taken));
    tgt = (ex_pc_sel == 2'b10) ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : (ex_pc + ex_imm);
    stall_prev = id_valid && !id_ready && !redir;
    prev_inst  = id_inst;
    prev_pc    = id_pc;
    if (redir) begin
      model_pc = tgt;
      exp_q.delete();
    end else if (id_valid && id_ready) begin
      accepts++;
      exp_q.push_back(model_pc);
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic wait_valid();
    bit found = 1'b0;
    nx_ready = 1'b0;
    clear_ex();
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (id_valid) begin found = 1'b1; break; end
    end
    check_eq("wait_valid_timeout", {31'b0, found}, 32'h1);
  endtask

  task automatic wait_req();
    bit found = 1'b0;
    nx_ready = 1'b1;
    clear_ex();
    for (int i = 0; i < 100; i++) begin
      cycle();
      if (imem_req) begin found = 1'b1; break; end
    end
    check_eq("wait_req_timeout", {31'b0, found}, 32'h1);
  endtask

  // Apply one control-flow event during HOLD and check the next address.
  task automatic redirect_check(input string tag, input logic [1:0] sel, input logic taken,
                                input logic [31:0] pc, input logic [31:0] imm,
                                input logic [31:0] rs1, input logic [31:0] exp_addr);
    wait_valid();
    nx_ex_valid = 1'b1; nx_sel = sel; nx_br_taken = taken;
    nx_ex_pc = pc; nx_imm = imm; nx_rs1 = rs1; nx_ready = 1'b0;
    cycle();
    clear_ex();
    cycle();
    check_eq({tag, "_req"}, {31'b0, imem_req}, 32'h1);
    check_eq({tag, "_addr"}, imem_addr, exp_addr);
    check_eq({tag, "_valid_drop"}, {31'b0, id_valid}, 32'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] seq_pc[3];
    int          seq_cyc[3];
    int          n;
    logic [31:0] held_pc, held_inst;

    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    id_ready = 1'b0; ex_valid = 1'b0; ex_pc_sel = 2'b00; ex_br_taken = 1'b0;
    ex_pc = 32'h0; ex_imm = 32'h0; ex_rs1 = 32'h0;
    force_en = 1'b0; saw_bad = 1'b0;
    clear_ex(); nx_ready = 1'b0;
    model_reset();

    // reset values
    repeat (2) cycle();
    check_eq("rst_req", {31'b0, imem_req}, 32'h0);
    check_eq("rst_addr", imem_addr, RST_PC);
    check_eq("rst_valid", {31'b0, id_valid}, 32'h0);
    check_eq("rst_inst", id_inst, 32'h0000_0013);
    check_eq("rst_id_pc", id_pc, RST_PC);
    check_eq("rst_pc4", id_pc4, RST_PC + 32'd4);
    check_eq("rst_state", {29'b0, dbg_state}, 32'h0);
    rst = 1'b0;

    // sequential fetch, zero-wait memory
    nx_ready = 1'b1;
    cycle();
    check_eq("first_req", {31'b0, imem_req}, 32'h1);
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      cycle();
      if (id_valid) begin
        if (n == 0) check_eq("seq_pc4", id_pc4, 32'h0000_0104);
        seq_pc[n] = id_pc; seq_cyc[n] = cyc_cnt; n++;
      end
    end
    check_eq("seq_count", n, 3);
    if (n == 3) begin
      check_eq("seq_pc0", seq_pc[0], 32'h0000_0100);
      check_eq("seq_pc1", seq_pc[1], 32'h0000_0104);
      check_eq("seq_pc2", seq_pc[2], 32'h0000_0108);
      check_eq("seq_gap1", seq_cyc[1] - seq_cyc[0], 3);
      check_eq("seq_gap2", seq_cyc[2] - seq_cyc[1], 3);
      check_eq("seq_order", exp_q[0], 32'h0000_0100);
    end

    // jal during HOLD
    redirect_check("jal", 2'b01, 1'b0, 32'h0000_0200, 32'hFFFF_FFF0, 32'h0, 32'h0000_01F0);

    // branch not taken: accepted, fetch continues at pc+4
    wait_valid();
    held_pc = id_pc;
    nx_ex_valid = 1'b1; nx_sel = 2'b11; nx_br_taken = 1'b0;
    nx_ex_pc = 32'h0000_0800; nx_imm = 32'h40; nx_ready = 1'b1;
    cycle();
    clear_ex(); nx_ready = 1'b0;
    cycle();
    check_eq("bnt_req", {31'b0, imem_req}, 32'h1);
    check_eq("bnt_addr", imem_addr, held_pc + 32'd4);

    // jalr, and a wrapping jal
    redirect_check("jalr", 2'b10, 1'b0, 32'h0000_0500, 32'h0000_0004, 32'h0000_1003, 32'h0000_1006);
    redirect_check("wrap", 2'b01, 1'b0, 32'hFFFF_FFFC, 32'h0000_0008, 32'h0, 32'h0000_0004);

    // redirect with a response outstanding
    lat_min = 3; lat_max = 3;
    wait_req();                         // granted this cycle (t)
    force_en = 1'b1; force_data = 32'hDEAD_BEEF;
    nx_ex_valid = 1'b1; nx_sel = 2'b01; nx_ex_pc = 32'h0000_0400; nx_imm = 32'h0;
    cycle();                            // t+1
    clear_ex();
    cycle();                            // t+2
    cycle();                            // t+3, stale rvalid
    check_eq("drop_req", {31'b0, imem_req}, 32'h0);
    cycle();                            // t+4
    check_eq("drop_req_after", {31'b0, imem_req}, 32'h1);
    check_eq("drop_addr", imem_addr, 32'h0000_0400);
    lat_min = 1; lat_max = 1;
    repeat (8) cycle();
    check_eq("no_deadbeef", {31'b0, saw_bad}, 32'h0);

    // backpressure
    wait_valid();
    held_pc = id_pc; held_inst = id_inst;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check_eq("bp_valid", {31'b0, id_valid}, 32'h1);
      check_eq("bp_inst", id_inst, held_inst);
      check_eq("bp_pc", id_pc, held_pc);
      check_eq("bp_req", {31'b0, imem_req}, 32'h0);
    end
    nx_ready = 1'b1;
    cycle();
    nx_ready = 1'b0;
    cycle();
    check_eq("bp_release_req", {31'b0, imem_req}, 32'h1);

    // asynchronous reset in HOLD
    wait_valid();
    #2 rst = 1'b1;
    #1;
    check_eq("arst_valid", {31'b0, id_valid}, 32'h0);
    check_eq("arst_addr", imem_addr, RST_PC);
    check_eq("arst_req", {31'b0, imem_req}, 32'h0);
    #1 rst = 1'b0;
    model_reset();
    wait_req();
    check_eq("arst_restart", imem_addr, RST_PC);

    // randomized traffic against the model
    gnt_pct = 70; lat_min = 1; lat_max = 4;
    accepts = 0;
    for (int i = 0; i < 2000; i++) begin
      nx_ready    = ($urandom_range(99) < 60);
      nx_ex_valid = ($urandom_range(5) == 0);
      nx_sel      = 2'($urandom_range(3));
      nx_br_taken = 1'($urandom_range(1));
      nx_ex_pc    = $urandom;
      nx_imm      = $urandom_range(1) ? $urandom : 32'($urandom_range(64)) - 32'd32;
      nx_rs1      = $urandom;
      cycle();
    end
    check_eq("rand_progress", {31'b0, accepts > 20}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
